mux3_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the 16-bit, 8-source operand mux (mux3) between up to 8 requesting datapath units in the stack processor. It grants bus ownership to one requester at a time and drives the mux's 3-bit control select. It enforces a bounded hold time, so a unit that keeps its request asserted cannot starve the other units.

---
 rtl/mux3_bus_arbiter.sv | 100 ++++++++++
 tb/tb_mux3_bus_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux3_bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-source mux3 operand bus.
// Grants one requester at a time and drives the mux select; bounded hold when contended.
module mux3_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Saturation point of the hold counter; all-ones when preemption is disabled.
    localparam logic [CNT_W-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [CNT_W-1:0] hold_q;
    logic [2:0]       last_q;
    logic [2:0]       sel_q;
    logic [7:0]       grant_q;
    logic             busy_q;
    logic             preempt_q;

    logic [2:0] win_d;
    logic       win_vld;
    logic [2:0] idx;
    logic       owner_req;
    logic       others_req;
    logic       limit_hit;

    // Scan last+1 .. last+8 (mod 8); the 3-bit add provides the wrap.
    always_comb begin
        win_d   = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!win_vld && req[idx]) begin
                win_d   = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req  = req[sel_q];
        others_req = |(req & ~grant_q);
        limit_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            last_q    <= 3'd7;
            sel_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        grant_q <= 8'b1 << win_d;
                        sel_q   <= win_d;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // Release takes precedence over a coinciding hold-limit revoke.
                    if (!owner_req || (limit_hit && others_req)) begin
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        last_q    <= sel_q;
                        state_q   <= IDLE;
                        preempt_q <= owner_req;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q <= hold_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// Bench for mux3_bus_arbiter: three instances (MAX_HOLD 8, 4, 0) against an owner-level model.
module tb_mux3_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;

    logic [7:0] g_o [3];
    logic [2:0] s_o [3];
    logic       b_o [3];
    logic       p_o [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux3_bus_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g_o[0]), .sel(s_o[0]), .busy(b_o[0]), .preempt(p_o[0]));
    mux3_bus_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g_o[1]), .sel(s_o[1]), .busy(b_o[1]), .preempt(p_o[1]));
    mux3_bus_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g_o[2]), .sel(s_o[2]), .busy(b_o[2]), .preempt(p_o[2]));

    // Model: who owns the bus, how many cycles it has owned it, who owned it last.
    int mh      [3] = '{8, 4, 0};
    int m_owner [3] = '{-1, -1, -1};
    int m_held  [3] = '{0, 0, 0};
    int m_last  [3] = '{7, 7, 7};
    int m_sel   [3] = '{0, 0, 0};
    int m_pre   [3] = '{0, 0, 0};

    typedef struct {
        logic       rst;
        logic [7:0] rq;
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
        logic       p;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] q);
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                m_owner[k] = -1; m_held[k] = 0; m_last[k] = 7; m_sel[k] = 0; m_pre[k] = 0;
            end else begin
                m_pre[k] = 0;
                if (m_owner[k] < 0) begin
                    for (int i = 1; i <= 8; i++) begin
                        int c;
                        c = (m_last[k] + i) % 8;
                        if (m_owner[k] < 0 && q[c]) begin
                            m_owner[k] = c; m_sel[k] = c; m_held[k] = 1;
                        end
                    end
                end else if (!q[m_owner[k]]) begin
                    m_last[k] = m_owner[k]; m_owner[k] = -1;
                end else if (mh[k] != 0 && m_held[k] >= mh[k] &&
                             (q & ~(8'd1 << m_owner[k])) != 8'd0) begin
                    m_last[k] = m_owner[k]; m_owner[k] = -1; m_pre[k] = 1;
                end else begin
                    m_held[k]++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q);
        @(negedge clk);
        rst_n = r;
        req   = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] eg;
            eg = (m_owner[k] < 0) ? 8'd0 : (8'd1 << m_owner[k]);
            chk($sformatf("model%0d.grant", k), 32'(g_o[k]), 32'(eg));
            chk($sformatf("model%0d.sel", k), 32'(s_o[k]), 32'(m_sel[k]));
            chk($sformatf("model%0d.busy", k), 32'(b_o[k]), 32'(m_owner[k] >= 0));
            chk($sformatf("model%0d.preempt", k), 32'(p_o[k]), 32'(m_pre[k]));
        end
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                       input logic [2:0] s, input logic b, input logic p, input int n);
        vec_t v;
        v.rst = r; v.rq = q; v.g = g; v.s = s; v.b = b; v.p = p;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] cur;
        int rr_exp [4] = '{0, 7, 0, 7};
        logic [7:0] rr_req [12] = '{8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h01,
                                    8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h01};

        // Expected values below are for the MAX_HOLD=4 instance.
        add(0, 8'hFF, 8'h00, 3'd0, 0, 0, 2);
        add(1, 8'hFF, 8'h01, 3'd0, 1, 0, 1);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        add(1, 8'h08, 8'h08, 3'd3, 1, 0, 2);
        add(1, 8'h00, 8'h00, 3'd3, 0, 0, 2);
        add(1, 8'h08, 8'h08, 3'd3, 1, 0, 1);
        add(1, 8'h00, 8'h00, 3'd3, 0, 0, 1);
        add(1, 8'h06, 8'h02, 3'd1, 1, 0, 4);
        add(1, 8'h06, 8'h00, 3'd1, 0, 1, 1);
        add(1, 8'h06, 8'h04, 3'd2, 1, 0, 4);
        add(1, 8'h06, 8'h00, 3'd2, 0, 1, 1);
        add(1, 8'h06, 8'h02, 3'd1, 1, 0, 4);
        add(1, 8'h04, 8'h00, 3'd1, 0, 0, 1);
        add(1, 8'h04, 8'h04, 3'd2, 1, 0, 1);
        add(1, 8'h02, 8'h00, 3'd2, 0, 0, 1);
        add(1, 8'h02, 8'h02, 3'd1, 1, 0, 8);
        add(1, 8'h00, 8'h00, 3'd1, 0, 0, 1);
        add(1, 8'h20, 8'h20, 3'd5, 1, 0, 1);
        add(0, 8'h20, 8'h00, 3'd0, 0, 0, 1);
        add(1, 8'h20, 8'h20, 3'd5, 1, 0, 1);

        @(posedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rq);
            chk($sformatf("tbl%0d.grant", i), 32'(g_o[1]), 32'(tbl[i].g));
            chk($sformatf("tbl%0d.sel", i), 32'(s_o[1]), 32'(tbl[i].s));
            chk($sformatf("tbl%0d.busy", i), 32'(b_o[1]), 32'(tbl[i].b));
            chk($sformatf("tbl%0d.preempt", i), 32'(p_o[1]), 32'(tbl[i].p));
        end

        // Round robin between sources 0 and 7, two-cycle ownerships.
        step(0, 8'h00); step(0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step(1, rr_req[i]);
            if (i % 3 == 0) chk("rr81.sel", 32'(s_o[1]), 32'(rr_exp[i / 3]));
            if (i % 3 == 2) chk("rr81.idle", 32'(b_o[1]), 32'(0));
        end

        // All sources requesting, single-cycle ownerships: sel walks 0..7,0.
        step(0, 8'h00);
        for (int k = 0; k < 9; k++) begin
            step(1, 8'hFF);
            chk("rrFF.sel", 32'(s_o[1]), 32'(k % 8));
            chk("rrFF.grant", 32'(g_o[1]), 32'(8'd1 << (k % 8)));
            step(1, 8'hFF & ~(8'd1 << (k % 8)));
            chk("rrFF.release", 32'(b_o[1]), 32'(0));
        end

        // Preemption disabled: owner 1 keeps the bus under contention.
        step(0, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step(1, 8'h06);
            chk("mh0.grant", 32'(g_o[2]), 32'(8'h02));
            chk("mh0.preempt", 32'(p_o[2]), 32'(0));
        end

        // Randomized traffic with long holds and occasional resets.
        cur = '0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 5))
                0:       cur = 8'($urandom);
                1:       cur = 8'($urandom) & 8'($urandom);
                2:       cur = cur ^ (8'd1 << $urandom_range(0, 7));
                default: cur = cur;
            endcase
            step($urandom_range(0, 63) != 0, cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
